// File: rtl/btb_pc_select_ctrl.sv
// rtl/btb_pc_select_ctrl.sv - BTB lookup, mispredict detection and recovery redirect for the fetch next-PC mux
// Define BTB_2BIT_COUNTER_EN to give each entry a 2-bit saturating direction counter.
module btb_pc_select_ctrl #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] fetch_pc,
  output logic        hit,
  output logic [31:0] predicted_target,
  output logic        r,
  output logic [31:0] recovery_pc,
  output logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_hit,
  input  logic [31:0] ex_pred_target,
  output logic [15:0] mispredict_count
);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
`endif
  logic [31:0]        recovery_pc_q, recovery_pc_d;
  logic [15:0]        mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]   f_idx, e_idx;
  logic [TAG_W-1:0]   f_tag, e_tag;
  logic               raw_hit, e_match, mispredict;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[31:IDX_W+2];

  always_comb begin
    raw_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
`ifdef BTB_2BIT_COUNTER_EN
    raw_hit = raw_hit && ctr_q[f_idx][1];
`endif
  end

  // The mux gives hit priority over r, so the prediction is masked while redirecting.
  assign r                = (state_q == RECOVER);
  assign flush            = r;
  assign hit              = raw_hit && !r;
  assign predicted_target = target_q[f_idx];
  assign recovery_pc      = recovery_pc_q;
  assign mispredict_count = mispredict_count_q;

  assign e_match = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  always_comb begin
    mispredict = 1'b0;
    if (ex_is_branch)
      mispredict = (ex_taken != ex_pred_hit) ||
                   (ex_taken && ex_pred_hit && (ex_target != ex_pred_target));
    else
      mispredict = ex_pred_hit;
  end

  always_comb begin
    state_d            = state_q;
    valid_d            = valid_q;
    tag_d              = tag_q;
    target_d           = target_q;
`ifdef BTB_2BIT_COUNTER_EN
    ctr_d              = ctr_q;
`endif
    recovery_pc_d      = recovery_pc_q;
    mispredict_count_d = mispredict_count_q;
    case (state_q)
      RUN: begin
        if (ex_valid) begin
          if (mispredict) begin
            state_d       = RECOVER;
            recovery_pc_d = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
            if (mispredict_count_q != 16'hFFFF)
              mispredict_count_d = mispredict_count_q + 16'd1;
          end
          if (ex_is_branch && ex_taken) begin
            valid_d[e_idx]  = 1'b1;
            tag_d[e_idx]    = e_tag;
            target_d[e_idx] = ex_target;
`ifdef BTB_2BIT_COUNTER_EN
            if (!e_match)
              ctr_d[e_idx] = 2'b10;
            else if (ctr_q[e_idx] != 2'b11)
              ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
`endif
          end else if (e_match) begin
`ifdef BTB_2BIT_COUNTER_EN
            if (!ex_is_branch)
              valid_d[e_idx] = 1'b0;
            else if (ctr_q[e_idx] != 2'b00)
              ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
`else
            valid_d[e_idx] = 1'b0;
`endif
          end
        end
      end
      RECOVER: begin
        if (!stall)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= RUN;
      valid_q            <= '0;
      recovery_pc_q      <= '0;
      mispredict_count_q <= '0;
`ifdef BTB_2BIT_COUNTER_EN
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
`endif
    end else begin
      state_q            <= state_d;
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      recovery_pc_q      <= recovery_pc_d;
      mispredict_count_q <= mispredict_count_d;
`ifdef BTB_2BIT_COUNTER_EN
      ctr_q              <= ctr_d;
`endif
    end
  end
endmodule

// File: tb/tb_btb_pc_select_ctrl.sv
// tb/tb_btb_pc_select_ctrl.sv - directed self-checking bench for btb_pc_select_ctrl (default build)
module tb_btb_pc_select_ctrl;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] fetch_pc;
  logic        hit, r, flush;
  logic [31:0] predicted_target, recovery_pc;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_hit;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [15:0] mispredict_count;

  int n_cmp = 0;
  int n_err = 0;

  btb_pc_select_ctrl #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_pc(fetch_pc),
    .hit(hit), .predicted_target(predicted_target), .r(r),
    .recovery_pc(recovery_pc), .flush(flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_hit(ex_pred_hit),
    .ex_pred_target(ex_pred_target), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic phit, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_hit    = phit;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_hit);
    fetch_pc = pc;
    #1;
    check(tag, 32'(hit), 32'(exp_hit));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; fetch_pc = 32'h0;
    resolve(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    repeat (2) tick();
    rst = 1'b0;
    fetch_pc = 32'h0040_0010;
    #1;
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_r", 32'(r), 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_cnt", 32'(mispredict_count), 32'd0);
    check("reset_rpc", recovery_pc, 32'h0);

    // Unpredicted taken branch: redirect, entry written but hit masked during recovery.
    resolve(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    tick(); idle();
    check("tk_r", 32'(r), 32'd1);
    check("tk_flush", 32'(flush), 32'd1);
    check("tk_hit_masked", 32'(hit), 32'd0);
    check("tk_rpc", recovery_pc, 32'h0040_0100);
    check("tk_cnt", 32'(mispredict_count), 32'd1);
    tick();
    check("tk_r_drop", 32'(r), 32'd0);
    check("tk_hit", 32'(hit), 32'd1);
    check("tk_ptgt", predicted_target, 32'h0040_0100);

    // Correctly predicted taken: no redirect.
    resolve(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
    tick(); idle();
    check("ok_r", 32'(r), 32'd0);
    check("ok_cnt", 32'(mispredict_count), 32'd1);

    // Predicted taken, resolved not-taken: fall through and drop the entry.
    resolve(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    tick(); idle();
    check("nt_r", 32'(r), 32'd1);
    check("nt_rpc", recovery_pc, 32'h0040_0014);
    check("nt_cnt", 32'(mispredict_count), 32'd2);
    tick();
    lookup("nt_hit_cleared", 32'h0040_0010, 1'b0);

    // Right direction, wrong target.
    resolve(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
    tick(); idle();
    check("tgt_r", 32'(r), 32'd1);
    check("tgt_rpc", recovery_pc, 32'h0040_0300);
    check("tgt_cnt", 32'(mispredict_count), 32'd3);
    tick();
    lookup("tgt_hit", 32'h0040_0020, 1'b1);
    check("tgt_ptgt", predicted_target, 32'h0040_0300);

    // Stalled recovery: r held 4 cycles; ex_* activity during RECOVER ignored.
    resolve(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    tick();
    stall = 1'b1;
    resolve(32'h0040_0040, 1'b1, 1'b1, 32'h0040_0400, 1'b0, 32'h0);
    check("st_r_c1", 32'(r), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("st_r_held", 32'(r), 32'd1);
      check("st_flush_held", 32'(flush), 32'd1);
      check("st_rpc_held", recovery_pc, 32'h0040_0100);
    end
    tick();
    stall = 1'b0;
    idle();
    check("st_r_c4", 32'(r), 32'd1);
    check("st_cnt", 32'(mispredict_count), 32'd4);
    tick();
    check("st_r_drop", 32'(r), 32'd0);
    lookup("st_no_write", 32'h0040_0040, 1'b0);
    lookup("st_entry", 32'h0040_0010, 1'b1);

    // Non-branch aliasing onto a valid entry.
    resolve(32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    tick(); idle();
    check("alias_rpc", recovery_pc, 32'h0040_0014);
    check("alias_cnt", 32'(mispredict_count), 32'd5);
    tick();
    lookup("alias_inval", 32'h0040_0010, 1'b0);

    // Fall-through address wraps at the top of memory.
    resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    tick(); idle();
    check("wrap_rpc", recovery_pc, 32'h0000_0000);
    tick();

    // Preload the counter near its ceiling instead of spending 65k redirects.
    force dut.mispredict_count_q = 16'hFFFD;
    #1;
    release dut.mispredict_count_q;
    for (int i = 0; i < 3; i++) begin
      resolve(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0500, 1'b0, 32'h0);
      tick(); idle();
      check("sat_cnt", 32'(mispredict_count), (i == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
      tick();
    end

    // Reset while redirecting.
    resolve(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0600, 1'b1, 32'h0040_0500);
    tick(); idle();
    check("rr_r_pre", 32'(r), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_r", 32'(r), 32'd0);
    check("rr_flush", 32'(flush), 32'd0);
    check("rr_cnt", 32'(mispredict_count), 32'd0);
    check("rr_rpc", recovery_pc, 32'h0);
    lookup("rr_hit", 32'h0040_0050, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/btb_pc_select_ctrl.md
# btb_pc_select_ctrl

Branch-target-buffer controller for the parallel-BTB MIPS fetch stage. Performs a combinational BTB lookup on the fetch PC and drives the `hit`/`r` selects and the predictor/recovery addresses for the 3-to-1 next-PC mux. Compares execute-stage branch resolution against the prediction carried down the pipe, sequences a one-cycle recovery redirect plus front-end flush on mispredict, and updates the BTB.

## Interface

Parameters:
- ENTRIES, 16, BTB entry count; power of two.
- IDX_W, 4, log2(ENTRIES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  front end frozen; holds a pending recovery.
- fetch_pc  in  32  current PC used for lookup.
- hit  out  1  predictor select to the next-PC mux.
- predicted_target  out  32  PredictorA input to the next-PC mux.
- r  out  1  recovery select to the next-PC mux.
- recovery_pc  out  32  Recovery input to the next-PC mux.
- flush  out  1  squash IF/ID this cycle.
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc  in  32  PC of the execute-stage instruction.
- ex_is_branch  in  1  instruction is a branch or jump.
- ex_taken  in  1  resolved direction.
- ex_target  in  32  resolved target.
- ex_pred_hit  in  1  `hit` value that accompanied this instruction from fetch.
- ex_pred_target  in  32  `predicted_target` that accompanied it.
- mispredict_count  out  16  saturating mispredict counter.

## Operation

- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0] (plus a 2-bit counter under the macro). Index = pc[IDX_W+1:2].
- Lookup, combinational: raw_hit = valid & tag match (& counter[1] under the macro). `predicted_target` = entry target whenever the index is in range, whether or not it hits.
- `hit` = raw_hit & ~r. The mux gives `hit` priority, so the controller must suppress it during recovery.
- FSM states: RUN and RECOVER.
- Mispredict, evaluated only in RUN with ex_valid=1:
  - Branch: ex_taken != ex_pred_hit, or (ex_taken & ex_pred_hit & ex_target != ex_pred_target).
  - Non-branch with ex_pred_hit=1 (aliasing).
- On mispredict: RUN→RECOVER; latch recovery_pc = ex_taken ? ex_target : ex_pc+4 (non-branch: ex_pc+4, 32-bit wrap); mispredict_count += 1, saturating at 16'hFFFF.
- In RECOVER: r=1, flush=1, hit=0.
  - stall=0: go to RUN next cycle.
  - stall=1: remain in RECOVER holding recovery_pc.
- In RECOVER, ex_* inputs are ignored: no update, no new mispredict.
- Updates apply in RUN with ex_valid=1:
  - Taken branch: write valid=1, tag, target.
  - Not-taken branch with tag match: clear valid.
  - Non-branch with matching tag: clear valid.
- Writes are visible the next cycle. There is no same-cycle read bypass.

## Timing

- Reset: all valid bits=0, counters=2'b01, state=RUN, r=0, flush=0, hit=0, recovery_pc=0, mispredict_count=0.
- Lookup latency: 0 cycles (`fetch_pc` to `hit`/`predicted_target`).
- Redirect latency: mispredict sampled at edge N gives r=flush=1 during cycle N+1. Minimum RECOVER duration is 1 cycle.
- Back-to-back mispredicts: the second resolution is ignored because it arrives during RECOVER (the squashed pipe).
- rst asserted in RECOVER: state returns to RUN next edge and r drops.
- rst has priority over every update.

## Configuration

- BTB_2BIT_COUNTER_EN defined:
  - Each entry carries a 2-bit saturating counter.
  - Taken branch on a miss allocates the entry with counter 2'b10. Taken branch on a tag match increments the counter (max 2'b11).
  - Not-taken branch on a tag match decrements the counter (min 2'b00) and keeps valid.
  - raw_hit requires counter[1]=1.
  - Non-branch aliasing still clears valid.
- Undefined: no counter storage; behaviour as in Operation.

## Test plan

- Reset, then fetch_pc=0x0040_0010 → hit=0, r=0, mispredict_count=0.
- Taken branch at ex_pc=0x0040_0010, target 0x0040_0100, ex_pred_hit=0 → next cycle r=1, flush=1, hit=0, recovery_pc=0x0040_0100, count=1. The following cycle fetch_pc=0x0040_0010 → hit=1, predicted_target=0x0040_0100.
- Predicted taken with ex_pred_target=0x0040_0100, resolved not-taken at ex_pc=0x0040_0010 → recovery_pc=0x0040_0014. Without the macro, a later lookup gives hit=0. With the macro, hit stays 1 until a second not-taken.
- Mispredict with stall=1 for 3 cycles → r=flush=1 held for 4 cycles total with recovery_pc stable. A mispredict presented on ex_* during RECOVER causes no count change and no BTB write.
- Non-branch at 0x0040_0010 arriving with ex_pred_hit=1 → recovery_pc=0x0040_0014 and the entry is invalidated. ex_pc=0xFFFF_FFFC not-taken mispredict → recovery_pc=0x0000_0000.
- Force 65,536 mispredicts → count holds at 0xFFFF. Assert rst during RECOVER → r=0 and count=0 after that edge.
